// File: rtl/frq_detector.sv
// Measures the period of an asynchronous divided clock in clk cycles and maps it onto a
// 5-bit frequency-select code through a 32-entry period table, with lock and loss detection.
module frq_detector (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sig_in,
    output logic [4:0] f_code,
    output logic [7:0] period,
    output logic       meas_valid,
    output logic       locked,
    output logic       no_signal
);

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StSearch,
        StUpdate
    } state_e;

    state_e     state_q;
    logic       sync1_q, sync2_q, prev_q;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cap_q;
    logic [4:0] idx_q;
    logic [4:0] f_code_q;
    logic [7:0] period_q;
    logic       meas_valid_q, locked_q, no_signal_q;
    logic [1:0] match_cnt_q, match_cnt_d;

    logic       edge_pulse;
    logic       timeout;
    logic       capture;
    logic [7:0] entry;
    logic [7:0] diff;
    logic       hit;

    // Period table: entry k holds the nominal period 2*(k+1) clk cycles.
    logic [7:0] p_tbl [32];
    for (genvar k = 0; k < 32; k++) begin : g_tbl
        assign p_tbl[k] = 8'(2 * (k + 1));
    end

    assign edge_pulse = sync2_q & ~prev_q;

    always_comb begin
        cnt_d = cnt_q;
        if (edge_pulse) begin
            cnt_d = 8'd0;
        end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // An edge in the same cycle as the counter reaching 255 takes priority over the timeout.
    assign timeout = (state_q != StIdle) && !edge_pulse && (cnt_d == 8'hFF);
    assign capture = (state_q == StMeasure) && edge_pulse && (cnt_q != 8'hFF);

    assign entry = p_tbl[idx_q];
    assign diff  = (entry >= cap_q) ? (entry - cap_q) : (cap_q - entry);
    assign hit   = (diff <= 8'd1);

    always_comb begin
        match_cnt_d = 2'd1;
        if ((idx_q == f_code_q) && (match_cnt_q != 2'd0)) begin
            match_cnt_d = (match_cnt_q == 2'd3) ? 2'd3 : match_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            cnt_q        <= 8'd0;
            cap_q        <= 8'd0;
            idx_q        <= 5'd0;
            f_code_q     <= 5'd0;
            period_q     <= 8'd0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            no_signal_q  <= 1'b0;
            match_cnt_q  <= 2'd0;
        end else begin
            sync1_q      <= sig_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            cnt_q        <= cnt_d;
            meas_valid_q <= 1'b0;
            if (edge_pulse) begin
                no_signal_q <= 1'b0;
            end
            if (timeout) begin
                no_signal_q <= 1'b1;
                locked_q    <= 1'b0;
                match_cnt_q <= 2'd0;
                state_q     <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (edge_pulse) begin
                            state_q <= StMeasure;
                        end
                    end
                    StMeasure: begin
                        if (capture) begin
                            cap_q   <= cnt_q + 8'd1;
                            idx_q   <= 5'd0;
                            state_q <= StSearch;
                        end
                    end
                    StSearch: begin
                        if (hit) begin
                            state_q <= StUpdate;
                        end else if (idx_q == 5'd31) begin
                            locked_q    <= 1'b0;
                            match_cnt_q <= 2'd0;
                            state_q     <= StMeasure;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                    StUpdate: begin
                        f_code_q     <= idx_q;
                        period_q     <= cap_q;
                        meas_valid_q <= 1'b1;
                        match_cnt_q  <= match_cnt_d;
                        locked_q     <= (match_cnt_d == 2'd3);
                        state_q      <= StMeasure;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign f_code     = f_code_q;
    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign no_signal  = no_signal_q;

endmodule
